// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the S1C88 interrupt-entry sequencer.
package irq_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RD_LO,
    RD_HI,
    DONE
  } state_e;

  localparam logic [23:0] DEFAULT_VECTOR_BASE = 24'h000000;
  localparam int          WAIT_W              = 8;

endpackage

// File: rtl/irq_level_enc.sv
// Highest-pending-level encoder: returns the index of the top set bit of irq_i[3:1].
module irq_level_enc (
  input  logic [3:0] irq_i,
  output logic [1:0] level_o
);

  // NOTE: every path assigns level_o, so this block cannot infer a latch.
  always_comb begin
    if (irq_i[3])      level_o = 2'd3;
    else if (irq_i[2]) level_o = 2'd2;
    else if (irq_i[1]) level_o = 2'd1;
    else               level_o = 2'd0;
  end

endmodule

// File: rtl/irq_entry_sequencer.sv
// Interrupt entry: mask compare, acknowledge, two-byte vector fetch, entry pulse.
module irq_entry_sequencer
  import irq_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter logic [23:0] VECTOR_BASE = DEFAULT_VECTOR_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cpu_irq,
  input  logic [1:0]  irq_mask,
  input  logic        insn_boundary,
  output logic        cpu_iack,
  output logic        bus_read,
  output logic [23:0] bus_address_out,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_ack,
  output logic        busy,
  output logic        entry_valid,
  output logic [15:0] entry_pc,
  output logic [1:0]  entry_level,
  output logic        spurious,
  output logic        bus_error
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(ACK_TIMEOUT);

  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [23:0]       addr_q;
  logic [7:0]        lo_q;
  logic [15:0]       entry_pc_q;
  logic [1:0]        entry_level_q;
  logic              bus_read_q;
  logic              entry_valid_q;
  logic              spurious_q;
  logic              bus_error_q;
  logic [1:0]        level;

  irq_level_enc u_level_enc (
    .irq_i   (cpu_irq),
    .level_o (level)
  );

  // NOTE: sequential state uses non-blocking assignments only; the pulse
  // outputs default low each cycle so any set below lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      addr_q        <= '0;
      lo_q          <= '0;
      entry_pc_q    <= '0;
      entry_level_q <= '0;
      bus_read_q    <= 1'b0;
      entry_valid_q <= 1'b0;
      spurious_q    <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      entry_valid_q <= 1'b0;
      spurious_q    <= 1'b0;
      bus_error_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (insn_boundary && (level > irq_mask)) begin
            entry_level_q <= level;
            state_q       <= ACK;
          end
        end
        ACK: begin
          // A request withdrawn before the acknowledge is dropped without any bus traffic.
          if (level == 2'd0) begin
            spurious_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            addr_q     <= VECTOR_BASE + {16'h0000, bus_data_in};
            wait_q     <= '0;
            bus_read_q <= 1'b1;
            state_q    <= RD_LO;
          end
        end
        RD_LO, RD_HI: begin
          if (bus_ack) begin
            wait_q <= '0;
            if (state_q == RD_LO) begin
              lo_q    <= bus_data_in;
              addr_q  <= addr_q + 24'd1;
              state_q <= RD_HI;
            end else begin
              entry_pc_q    <= {bus_data_in, lo_q};
              entry_valid_q <= 1'b1;
              bus_read_q    <= 1'b0;
              state_q       <= DONE;
            end
          end else if (wait_q == TIMEOUT_CNT) begin
            bus_error_q <= 1'b1;
            bus_read_q  <= 1'b0;
            state_q     <= IDLE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_iack        = (state_q == ACK);
  assign busy            = (state_q != IDLE);
  assign bus_read        = bus_read_q;
  assign bus_address_out = addr_q;
  assign entry_valid     = entry_valid_q;
  assign entry_pc        = entry_pc_q;
  assign entry_level     = entry_level_q;
  assign spurious        = spurious_q;
  assign bus_error       = bus_error_q;

endmodule
